instr_encoder: RTL and testbench

- Encoder counterpart to the opcode decoder. Takes one-hot operation requests (rtype/sw/lw/beq) plus register fields and packs them into 16-bit instruction words.
- Buffers the encoded words in a small FIFO for the instruction-memory loader or test sequencer downstream.
- Flags and drops malformed (non-one-hot) requests.
- Sits between the program-generation logic and instruction memory.

---
 rtl/isa_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 80 ++++++++
 rtl/instr_encoder.sv | 124 ++++++++++++
 tb/tb_instr_encoder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// isa_pkg -- instruction-set constants shared by the instruction encoder
// and the opcode decoder.
//   INSTR_W          : instruction word width (16)
//   OP_*             : 4-bit opcodes for rtype / sw / lw / beq
//   *_MSB / *_LSB    : bit positions of the opcode, rs, rt and rd/imm fields
//   word_parity()    : even-parity (XOR reduction) of an instruction word
package isa_pkg;

    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_SW    = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_BEQ   = 4'b0011;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RS_MSB  = 11;
    localparam int RS_LSB  = 8;
    localparam int RT_MSB  = 7;
    localparam int RT_LSB  = 4;
    localparam int RD_MSB  = 3;
    localparam int RD_LSB  = 0;

    function automatic logic word_parity(input logic [INSTR_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock FIFO with an explicit occupancy counter and a
// registered head-of-queue output.
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, wr_data   : write request / data (ignored while full)
//   pop             : read request (ignored while empty)
//   full, empty     : occupancy flags derived from level
//   level           : current number of stored entries (0..DEPTH)
//   rd_data         : word at the head of the queue (registered)
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         rd_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
    logic [LVL_W-1:0] level_reg, level_next;
    logic [WIDTH-1:0] rd_data_reg;
    logic             do_push, do_pop;

    assign full    = (level_reg == LVL_W'(DEPTH));
    assign empty   = (level_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(do_push);
        rd_ptr_next = rd_ptr_reg + PTR_W'(do_pop);
        level_next  = level_reg;
        if (do_push && !do_pop)
            level_next = level_reg + LVL_W'(1);
        else if (do_pop && !do_push)
            level_next = level_reg - LVL_W'(1);
    end

    // Storage array: no reset so it can map onto RAM resources.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            level_reg   <= '0;
            rd_data_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            // Preload the next head word. When the slot being written this
            // cycle is the next head (push into an empty or about-to-empty
            // queue), forward the write data since mem is not yet updated.
            // When the queue goes empty the register keeps the last head.
            if (level_next != '0) begin
                if (do_push && (wr_ptr_reg == rd_ptr_next))
                    rd_data_reg <= wr_data;
                else
                    rd_data_reg <= mem[rd_ptr_next];
            end
        end
    end

    assign level   = level_reg;
    assign rd_data = rd_data_reg;

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder -- packs one-hot operation requests plus register fields into
// 16-bit instruction words and queues them for the downstream loader.
// Malformed requests (zero or several op flags) are consumed, dropped, and
// reported by an err pulse and a saturating err_cnt.
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid / in_ready    : request handshake (in_ready = not full)
//   rtype, sw, lw, beq     : one-hot operation select
//   rs, rt, rd             : register fields (rd doubles as 4-bit immediate)
//   out_valid / out_ready  : output handshake on the FIFO head
//   out_instr              : encoded word at the FIFO head
//   err, err_cnt           : malformed-request pulse and saturating count
//   level                  : FIFO occupancy
//   out_par                : even parity of out_instr, only when the macro
//                            INSTR_ENCODER_PARITY_EN is defined
module instr_encoder
    import isa_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   rtype,
    input  logic                   sw,
    input  logic                   lw,
    input  logic                   beq,
    input  logic [3:0]             rs,
    input  logic [3:0]             rt,
    input  logic [3:0]             rd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_W-1:0]     out_instr,
    output logic                   err,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [$clog2(DEPTH):0] level
`ifdef INSTR_ENCODER_PARITY_EN
    ,
    output logic                   out_par
`endif
);
`ifdef INSTR_ENCODER_PARITY_EN
    localparam int STORE_W = INSTR_W + 1;
`else
    localparam int STORE_W = INSTR_W;
`endif

    logic [3:0]         flags;
    logic               legal;
    logic [3:0]         opcode;
    logic [INSTR_W-1:0] word;
    logic [STORE_W-1:0] store_word, head_word;
    logic               accept, push, bad;
    logic               full, empty;
    logic               err_reg;
    logic [CNT_W-1:0]   err_cnt_reg;

    assign flags = {rtype, sw, lw, beq};
    assign legal = $onehot(flags);

    always_comb begin
        opcode = OP_RTYPE;
        case (flags)
            4'b1000: opcode = OP_RTYPE;
            4'b0100: opcode = OP_SW;
            4'b0010: opcode = OP_LW;
            4'b0001: opcode = OP_BEQ;
            default: opcode = OP_RTYPE;
        endcase
    end

    always_comb begin
        word                   = '0;
        word[OPC_MSB:OPC_LSB]  = opcode;
        word[RS_MSB:RS_LSB]    = rs;
        word[RT_MSB:RT_LSB]    = rt;
        word[RD_MSB:RD_LSB]    = rd;
    end

`ifdef INSTR_ENCODER_PARITY_EN
    assign store_word = {word_parity(word), word};
    assign out_par    = head_word[INSTR_W];
`else
    assign store_word = word;
`endif

    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && legal;
    assign bad      = accept && !legal;

    sync_fifo #(
        .WIDTH (STORE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (store_word),
        .pop     (out_ready),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .rd_data (head_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            err_reg <= bad;
            if (bad && (err_cnt_reg != '1))
                err_cnt_reg <= err_cnt_reg + CNT_W'(1);
        end
    end

    assign out_valid = !empty;
    assign out_instr = head_word[INSTR_W-1:0];
    assign err       = err_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder -- scoreboard bench for instr_encoder. The stimulus side
// pushes the hand-computed expected word into a queue when a legal request
// is accepted; a monitor pops and compares on every output handshake.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        rtype = 1'b0, sw = 1'b0, lw = 1'b0, beq = 1'b0;
    logic [3:0]  rs = '0, rt = '0, rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic        err;
    logic [7:0]  err_cnt;
    logic [2:0]  level;
`ifdef INSTR_ENCODER_PARITY_EN
    logic        out_par;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] sb [$];

    instr_encoder #(.DEPTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rtype     (rtype),
        .sw        (sw),
        .lw        (lw),
        .beq       (beq),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .err       (err),
        .err_cnt   (err_cnt),
        .level     (level)
`ifdef INSTR_ENCODER_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: compare every output handshake against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL pop: got %h expected no word (queue empty)", out_instr);
                end else begin
                    logic [15:0] exp_w;
                    exp_w = sb.pop_front();
                    if (out_instr !== exp_w) begin
                        errors++;
                        $display("FAIL pop: got %h expected %h", out_instr, exp_w);
                    end else begin
                        $display("ok   pop: %h", out_instr);
                    end
`ifdef INSTR_ENCODER_PARITY_EN
                    checks++;
                    if (out_par !== ^exp_w) begin
                        errors++;
                        $display("FAIL par: got %b expected %b for %h", out_par, ^exp_w, exp_w);
                    end
`endif
                end
            end
        end
    end

    // Drive one request (flags = {rtype,sw,lw,beq}); waits up to 20 cycles
    // for in_ready. exp_w is the hand-computed word for legal requests.
    task automatic send(input logic [3:0] f, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [15:0] exp_w);
        bit done = 0;
        {rtype, sw, lw, beq} = f;
        rs = a; rt = b; rd = c;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
                if ($onehot(f)) sb.push_back(exp_w);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout: got in_ready=0 expected acceptance within 20 cycles");
        end
    endtask

    task automatic wait_empty();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (level == 0) done = 1;
        end
        @(posedge clk); #1;
        check("drain_level", 32'(level), 32'd0);
        check("drain_sb", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_level", 32'(level), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", 32'(out_instr), 32'h0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single lw, out_ready high: appears next cycle, then empty
        out_ready = 1'b1;
        send(4'b0010, 4'h3, 4'h5, 4'h7, 16'h2357);
        check("lw_out_valid_next", 32'(out_valid), 32'd1);
        check("lw_out_instr_next", 32'(out_instr), 32'h2357);
        wait_empty();

        // Fill with consumer stalled
        out_ready = 1'b0;
        send(4'b0100, 4'h1, 4'h2, 4'h3, 16'h1123);
        send(4'b0001, 4'h4, 4'h5, 4'h6, 16'h3456);
        send(4'b1000, 4'h7, 4'h8, 4'h9, 16'h0789);
        send(4'b0010, 4'hA, 4'hB, 4'hC, 16'h2ABC);
        check("full_level", 32'(level), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("stall_hold", 32'(out_instr), 32'h1123);

        // 5th request held while full: not accepted
        {rtype, sw, lw, beq} = 4'b1000; rs = 4'h1; rt = 4'h2; rd = 4'h3;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("fifth_blocked_level", 32'(level), 32'd4);
        check("fifth_blocked_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;

        // Release consumer with the request still pending: it enters only
        // once a pop has freed a slot; order is preserved.
        out_ready = 1'b1;
        @(negedge clk);
        check("release_ready_still_0", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        send(4'b1000, 4'h1, 4'h2, 4'h3, 16'h0123);
        send(4'b0100, 4'hF, 4'hE, 4'hD, 16'h1FED);
        wait_empty();

        // Malformed: rtype+lw
        send(4'b1010, 4'h1, 4'h1, 4'h1, 16'h0);
        check("bad1_err", 32'(err), 32'd1);
        check("bad1_err_cnt", 32'(err_cnt), 32'd1);
        check("bad1_level", 32'(level), 32'd0);
        @(posedge clk); #1;
        check("bad1_err_pulse_end", 32'(err), 32'd0);
        // Malformed: no flags
        send(4'b0000, 4'h2, 4'h2, 4'h2, 16'h0);
        check("bad2_err_cnt", 32'(err_cnt), 32'd2);
        // 298 more back-to-back -> 300 total, saturates
        {rtype, sw, lw, beq} = 4'b0000;
        in_valid = 1'b1;
        repeat (298) @(posedge clk);
        #1 in_valid = 1'b0;
        check("bad_sat", 32'(err_cnt), 32'hFF);
        send(4'b1111, 4'h0, 4'h0, 4'h0, 16'h0);
        check("bad_sat_hold", 32'(err_cnt), 32'hFF);
        check("bad_level", 32'(level), 32'd0);

        // Async reset mid-stream with level 3
        out_ready = 1'b0;
        send(4'b0100, 4'h1, 4'h1, 4'h1, 16'h1111);
        send(4'b0100, 4'h2, 4'h2, 4'h2, 16'h1222);
        send(4'b0100, 4'h3, 4'h3, 4'h3, 16'h1333);
        check("pre_rst_level", 32'(level), 32'd3);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        check("async_rst_level", 32'(level), 32'd0);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_out_instr", 32'(out_instr), 32'h0);
        check("async_rst_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b1;
        send(4'b0001, 4'h9, 4'h8, 4'h7, 16'h3987);
        wait_empty();

`ifdef INSTR_ENCODER_PARITY_EN
        out_ready = 1'b0;
        send(4'b1000, 4'h1, 4'h0, 4'h0, 16'h0100);
        check("par_0100", 32'(out_par), 32'd1);
        out_ready = 1'b1;
        send(4'b0001, 4'h0, 4'h0, 4'h0, 16'h3000);
        wait_empty();
        check("par_3000_last", 32'(out_par), 32'd0);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
